sw_debounce: RTL

- Conditions raw slide-switch inputs before they reach the 16-bit switch PIO input port on the Nios core.
- Synchronises each asynchronous switch line to clk and debounces it against a shared sample tick.
- Drives a stable, glitch-free word to the PIO in_port.
- Also produces per-bit rise/fall pulses and a word-level change pulse for optional interrupt or edge-capture logic.

---
 rtl/sw_debounce_pkg.sv | 27 ++
 rtl/sw_debounce_bit.sv | 64 ++++++
 rtl/sw_debounce.sv | 61 ++++++
 3 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and width helpers for the switch debouncer.
//   clog2    : ceiling log2 of a positive integer
//   presc_w  : prescaler counter width for a given TICK_DIV (min 1 bit)
//   cnt_w    : per-bit stability counter width for STABLE_TICKS (min 1 bit)
package sw_debounce_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_TICK_DIV     = 50000;   // 1 ms at 50 MHz
    localparam int DEF_STABLE_TICKS = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // TICK_DIV=1 gives clog2=0; keep a 1-bit counter that stays at 0.
    function automatic int presc_w(input int tick_div);
        return (clog2(tick_div) < 1) ? 1 : clog2(tick_div);
    endfunction

    function automatic int cnt_w(input int stable_ticks);
        return (clog2(stable_ticks) < 1) ? 1 : clog2(stable_ticks);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch line: 2-flop synchroniser, stability counter, clean flop and
// registered edge pulses.
//   clk, reset_n : clock, async active-low reset
//   raw          : asynchronous switch pin
//   tick         : shared sample strobe from the prescaler
//   clean        : debounced level (flop)
//   rise, fall   : one-cycle pulses, registered with the clean update
//   flip         : combinational "clean toggles on this edge", used by the
//                  parent to register the word-level change pulse
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic tick,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam int CNT_W = cnt_w(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // Qualification threshold reached on this sample: clean toggles now.
    assign flip = tick && (sync_q2 != clean) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            clean   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            fall    <= 1'b0;
            if (tick) begin
                if (sync_q2 == clean) begin
                    // Any agreeing sample restarts qualification.
                    cnt <= '0;
                end else if (flip) begin
                    clean <= ~clean;
                    cnt   <= '0;
                    rise  <= ~clean;
                    fall  <= clean;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner feeding the switch PIO in_port.
//   clk, reset_n : clock, async active-low reset
//   sw_raw       : raw switch pins, asynchronous to clk
//   sw_clean     : debounced word (to PIO in_port)
//   sw_rise      : per-bit 0->1 pulse, first cycle the clean bit reads 1
//   sw_fall      : per-bit 1->0 pulse, first cycle the clean bit reads 0
//   sw_changed   : one-cycle pulse when any clean bit changes
// All outputs are flops; the prescaler free-runs regardless of input.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam int PRESC_W = presc_w(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [WIDTH-1:0]   flip;

    // With TICK_DIV=1 presc stays 0 == PRESC_MAX, so tick is constant high.
    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) presc <= '0;
        else          presc <= tick ? '0 : presc + PRESC_W'(1);
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (sw_raw[g]),
            .tick    (tick),
            .clean   (sw_clean[g]),
            .rise    (sw_rise[g]),
            .fall    (sw_fall[g]),
            .flip    (flip[g])
        );
    end

    // Registered alongside the per-bit edge flops, so it lines up with them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sw_changed <= 1'b0;
        else          sw_changed <= |flip;
    end

endmodule
